// File: rtl/eip_sequencer_if.sv
// Decode-to-sequencer bus: per-cycle op request plus the instruction pointer and
// return-stack status returned toward fetch/decode.
interface eip_sequencer_if #(
  parameter int WIDTH       = 32,
  parameter int STACK_DEPTH = 4,
  parameter int LEN_W       = 4
);
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic             op_valid;
  logic             stall;
  logic [2:0]       op;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] eip;
  logic             redirect;
  logic [CW-1:0]    stack_count;
  logic             stack_empty;
  logic             stack_full;
  logic             fault;
  logic [1:0]       fault_code;

  modport master (
    output op_valid, stall, op, len, target,
    input  eip, redirect, stack_count, stack_empty, stack_full, fault, fault_code
  );

  modport slave (
    input  op_valid, stall, op, len, target,
    output eip, redirect, stack_count, stack_empty, stack_full, fault, fault_code
  );
endinterface

// File: rtl/eip_sequencer.sv
// Instruction-pointer sequencer with return-address stack (sequential advance, jumps, call/return).
// Define EIP_FAULT_EN to build the sticky fault flag; otherwise fault/fault_code are tied to 0.
module eip_sequencer #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR  = WIDTH'(32'h0000_000b),
  parameter int               STACK_DEPTH = 4,
  parameter int               LEN_W       = 4
) (
  input logic           clock,
  input logic           reset,
  eip_sequencer_if.slave bus
);

  localparam int            CW         = $clog2(STACK_DEPTH + 1);
  localparam int            IW         = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADV  = 3'd1,
    OP_JMP  = 3'd2,
    OP_JREL = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_t;

  op_t              op;
  logic             accept;
  logic             len_legal;
  logic             full;
  logic             empty;
  logic             push;
  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] eip_q;
  logic [WIDTH-1:0] eip_next;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             redirect_q;
  logic             redirect_next;
  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

  assign op        = op_t'(bus.op);
  assign accept    = bus.op_valid && !bus.stall;
  assign seq       = eip_q + WIDTH'(bus.len);
  assign len_legal = (bus.len == LEN_W'(1)) || (bus.len == LEN_W'(2)) ||
                     (bus.len == LEN_W'(4)) || (bus.len == LEN_W'(5));
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_COUNT);
  assign tos       = stack_mem[IW'(count_q - CW'(1))];

  // JREL wraps modulo 2^WIDTH, so adding the raw displacement is the signed add.
  always_comb begin
    eip_next      = eip_q;
    count_next    = count_q;
    redirect_next = 1'b0;
    push          = 1'b0;
    if (accept) begin
      case (op)
        OP_ADV: begin
          if (len_legal) eip_next = seq;
        end
        OP_JMP: begin
          eip_next      = bus.target;
          redirect_next = 1'b1;
        end
        OP_JREL: begin
          eip_next      = seq + bus.target;
          redirect_next = 1'b1;
        end
        OP_CALL: begin
          push          = 1'b1;
          eip_next      = bus.target;
          redirect_next = 1'b1;
          if (!full) count_next = count_q + CW'(1);
        end
        OP_RET: begin
          if (empty) begin
            eip_next = seq;
          end else begin
            eip_next      = tos;
            count_next    = count_q - CW'(1);
            redirect_next = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      eip_q      <= RESET_ADDR;
      count_q    <= '0;
      redirect_q <= 1'b0;
    end else begin
      eip_q      <= eip_next;
      count_q    <= count_next;
      redirect_q <= redirect_next;
    end
  end

  // A push into a full stack shifts out the oldest entry so the newest stays at the top slot.
  always_ff @(posedge clock) begin
    if (push) begin
      if (full) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) stack_mem[i] <= stack_mem[i+1];
        stack_mem[STACK_DEPTH-1] <= seq;
      end else begin
        stack_mem[IW'(count_q)] <= seq;
      end
    end
  end

`ifdef EIP_FAULT_EN
  logic       fault_q;
  logic [1:0] code_q;
  logic [1:0] code_event;

  always_comb begin
    code_event = 2'd0;
    if (accept) begin
      if (op == OP_CALL && full)            code_event = 2'd1;
      else if (op == OP_RET && empty)       code_event = 2'd2;
      else if (op == OP_ADV && !len_legal)  code_event = 2'd3;
    end
  end

  // Only the first fault is recorded; later events are ignored until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      fault_q <= 1'b0;
      code_q  <= 2'd0;
    end else if (!fault_q && code_event != 2'd0) begin
      fault_q <= 1'b1;
      code_q  <= code_event;
    end
  end

  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
`else
  assign bus.fault      = 1'b0;
  assign bus.fault_code = 2'd0;
`endif

  assign bus.eip         = eip_q;
  assign bus.redirect    = redirect_q;
  assign bus.stack_count = count_q;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;

endmodule

// File: doc/eip_sequencer.md
Name: eip_sequencer

Overview:
Parametrised successor to the instruction-pointer register: holds the current instruction pointer (eip) and computes its next value each cycle. Supports sequential advance by instruction length, absolute and relative jumps, and call/return through an internal return-address stack. Runs on a single clock and feeds the fetch stage; the decode stage drives it with one operation per cycle.

Parameters:
WIDTH, 32, eip and address width in bits
RESET_ADDR, 32'h0000000b, eip value loaded on reset
STACK_DEPTH, 4, return-address stack entries (>=1)
LEN_W, 4, width of the instruction-length input

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
op_valid  input  1  op/len/target valid this cycle
stall  input  1  freeze all state; overrides op_valid
op  input  3  0 NOP, 1 ADV, 2 JMP, 3 JREL, 4 CALL, 5 RET, 6-7 NOP
len  input  LEN_W  length of current instruction in bytes
target  input  WIDTH  absolute address (JMP/CALL) or signed displacement (JREL)
eip  output  WIDTH  current instruction pointer (registered)
redirect  output  1  registered 1-cycle pulse after a taken JMP/JREL/CALL/RET
stack_count  output  clog2(STACK_DEPTH+1)  occupied stack entries
stack_empty  output  1  stack_count==0
stack_full  output  1  stack_count==STACK_DEPTH
fault  output  1  sticky error flag (see Optional Feature)
fault_code  output  2  0 none, 1 overflow, 2 underflow, 3 illegal length

Behaviour:
- Reset (synchronous, wins over everything): eip=RESET_ADDR, stack_count=0, redirect=0, fault=0, fault_code=0; stack contents don't-care.
- Update condition: posedge clock with op_valid=1 and stall=0. Otherwise all state holds; redirect drops to 0.
- Latency: eip reflects an op one cycle after it is accepted. No bubbles; back-to-back ops accepted every cycle.
- seq = eip + len, with len zero-extended. Legal len values are 1, 2, 4 and 5.
- ADV: eip<=seq if len legal; illegal len leaves eip unchanged.
- JMP: eip<=target.
- JREL: eip<=seq + target, with target treated as two's complement.
- CALL: push seq; eip<=target.
- RET: eip<=top-of-stack; pop.
- All arithmetic is modulo 2^WIDTH; wrap past all-ones is silent.
- Any len is accepted for JMP/CALL/JREL/RET; illegal len only affects ADV and the fault logic.
- redirect=1 in the cycle after any accepted JMP, JREL or CALL, and after a RET that pops a valid entry.
- Stack is LIFO with the top at index stack_count-1.
- CALL when full: the oldest entry is discarded (circular), the new entry becomes top, and stack_count stays STACK_DEPTH.
- RET when empty: eip<=seq (fall-through), stack_count stays 0, redirect=0.
- Simultaneous stall and op_valid: the op is dropped, not queued; the driver re-presents it.
- Reset asserted mid-sequence discards all stacked addresses.

Optional Feature:
EIP_FAULT_EN:
- Defined: fault sets sticky on CALL-when-full (code 1), RET-when-empty (code 2), or ADV with illegal len (code 3). The first fault's code is held until reset; fault clears only on reset.
- Undefined: fault and fault_code are tied to 0 and no fault logic is built. Datapath behaviour is identical in both builds.

Test Plan:
- Reset, then ADV len=1, 2, 4, 5 on consecutive cycles -> eip 0x0b, 0x0c, 0x0e, 0x12, 0x17; redirect stays 0.
- eip=0x100: JREL len=2 target=0xFFFFFFF0 -> eip=0x0F2, redirect pulses for 1 cycle; JMP target=0xFFFFFFFF then ADV len=1 -> eip=0x00000000 (wrap).
- eip=0x20: CALL len=5 target=0x80, then RET -> eip 0x80 then 0x25; stack_count goes 1 then 0.
- STACK_DEPTH=4: five CALLs from eip 0x10, 0x20, 0x30, 0x40, 0x50 with len=1, then five RETs -> RETs return 0x51, 0x41, 0x31, 0x21, then the fifth falls through. With EIP_FAULT_EN: fault=1, fault_code=1 (overflow recorded first, held).
- stall=1 held 3 cycles with op_valid=1 op=ADV -> eip unchanged; then stall=0 -> single advance only.
- ADV len=3 -> eip unchanged. With EIP_FAULT_EN: fault=1, fault_code=3. Then reset mid-CALL-sequence -> eip=0x0b, stack_count=0, fault=0.
